// File: rtl/csram_sync_if.sv
// Request/response bus of the clocked program SRAM.
// The core side drives the master modport, the RAM the slave modport.
interface csram_sync_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  boot_done;

  modport master (
    output req_valid, req_write, req_address, req_data,
    input  req_ready, rsp_valid, rsp_data, boot_done
  );

  modport slave (
    input  req_valid, req_write, req_address, req_data,
    output req_ready, rsp_valid, rsp_data, boot_done
  );
endinterface

// File: rtl/csram_sync.sv
// Clocked single-port program SRAM with boot image fill and wait states.
// Optional CSRAM_SYNC_WRITE_PROTECT_EN makes the boot image words read-only.
module csram_sync #(
  parameter int                       DATA_WIDTH  = 16,
  parameter int                       ADDR_WIDTH  = 16,
  parameter int                       DEPTH_LOG2  = 8,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR   = 16'h3000,
  parameter int                       WAIT_STATES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  csram_sync_if.slave  bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    BOOT, IDLE, WAIT, RESP
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [WORDS];
  logic [DEPTH_LOG2-1:0]   boot_idx;
  logic [3:0]              wait_cnt;
  logic [DATA_WIDTH-1:0]   pend_data;

  logic [ADDR_WIDTH:0]     addr_x;
  logic [ADDR_WIDTH:0]     win_lo;
  logic [ADDR_WIDTH:0]     win_hi;
  logic                    hit;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    prot;
  logic                    accept;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   rsp_word;

  function automatic logic [DATA_WIDTH-1:0] boot_word(
    input logic [DEPTH_LOG2-1:0] i
  );
    logic [DATA_WIDTH-1:0] w;
    w = '1;
    case (32'(i))
      0: w = DATA_WIDTH'(16'h9040);
      1: w = DATA_WIDTH'(16'h5060);
      2: w = DATA_WIDTH'(16'h1027);
      3: w = DATA_WIDTH'(16'h103f);
      4: w = DATA_WIDTH'(16'h0bfe);
      5: w = DATA_WIDTH'(16'hf030);
      6: w = DATA_WIDTH'(16'h0ff9);
      default: w = '1;
    endcase
    return w;
  endfunction

  // One extra bit keeps a window at the top of the map from wrapping.
  assign addr_x = {1'b0, bus.req_address};
  assign win_lo = {1'b0, BASE_ADDR};
  assign win_hi = win_lo + (ADDR_WIDTH+1)'(WORDS);
  assign hit    = (addr_x >= win_lo) && (addr_x < win_hi);
  assign idx    = DEPTH_LOG2'(bus.req_address - BASE_ADDR);

`ifdef CSRAM_SYNC_WRITE_PROTECT_EN
  assign prot = hit && (32'(idx) < 7);
`else
  assign prot = 1'b0;
`endif

  assign accept = bus.req_ready && bus.req_valid;
  assign mem_we = accept && bus.req_write && hit && !prot;

  // Contents only change on accept edges, so the answer is fixed here.
  always_comb begin
    rsp_word = '1;
    if (bus.req_write && !prot)
      rsp_word = bus.req_data;
    else if (hit)
      rsp_word = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (state == BOOT)
      mem[boot_idx] <= boot_word(boot_idx);
    else if (mem_we)
      mem[idx] <= bus.req_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= BOOT;
      boot_idx      <= '0;
      wait_cnt      <= '0;
      pend_data     <= '1;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '1;
      bus.boot_done <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          boot_idx <= boot_idx + 1'b1;
          if (boot_idx == '1) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.boot_done <= 1'b1;
          end
        end
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= rsp_word;
            end else begin
              state     <= WAIT;
              wait_cnt  <= 4'(WAIT_STATES - 1);
              pend_data <= rsp_word;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= pend_data;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_csram_sync.sv
// Bench for csram_sync: vector table, random traffic vs a word-array
// model, a zero-wait-state streaming instance and a reset-in-WAIT case.
module tb_csram_sync;

`ifdef CSRAM_SYNC_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  csram_sync_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) b1 ();
  csram_sync_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) b0 ();

  csram_sync #(.WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1)
  );
  csram_sync #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] model [256];

  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] e;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] boot_ref(input int off);
    logic [15:0] img [7];
    img = '{16'h9040, 16'h5060, 16'h1027, 16'h103f,
            16'h0bfe, 16'hf030, 16'h0ff9};
    if (off >= 0 && off < 7) return img[off];
    return 16'hffff;
  endfunction

  task automatic model_boot();
    for (int i = 0; i < 256; i++) model[i] = boot_ref(i);
  endtask

  function automatic logic [15:0] ref_access(input logic wr,
      input logic [15:0] a, input logic [15:0] d);
    int off;
    bit hit;
    bit ro;
    off = int'(a) - 'h3000;
    hit = off >= 0 && off < 256;
    ro  = WP && hit && off < 7;
    if (wr) begin
      if (hit && !ro) model[off] = d;
      return ro ? model[off] : d;
    end
    return hit ? model[off] : 16'hffff;
  endfunction

  task automatic req1(input logic wr, input logic [15:0] a,
      input logic [15:0] d, output logic [15:0] rsp, output int lat);
    int n;
    rsp = 'x;
    lat = -1;
    n = 0;
    while (!b1.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b1.req_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    b1.req_valid = 1'b1;
    b1.req_write = wr;
    b1.req_address = a;
    b1.req_data = d;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      b1.req_valid = 1'b0;
      if (b1.rsp_valid) begin
        lat = k;
        rsp = b1.rsp_data;
        break;
      end
    end
    if (lat < 0) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    @(negedge clk);
    check("rsp_pulse", 32'(b1.rsp_valid), 0);
    check("rsp_hold", 32'(b1.rsp_data), 32'(rsp));
  endtask

  task automatic boot_wait();
    int cnt;
    bit bad;
    cnt = 0;
    bad = 1'b0;
    while (!b1.boot_done && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (!b1.boot_done && (b1.req_ready || b1.rsp_valid)) bad = 1'b1;
    end
    check("boot_cycles", 32'(cnt), 256);
    check("boot_quiet", 32'(bad), 0);
    check("boot_ready", 32'(b1.req_ready), 1);
    check("boot0_done", 32'(b0.boot_done), 1);
  endtask

  initial begin
    logic [15:0] rsp;
    logic [15:0] exp;
    int lat;

    b1.req_valid = 1'b0;
    b1.req_write = 1'b0;
    b1.req_address = '0;
    b1.req_data = '0;
    b0.req_valid = 1'b0;
    b0.req_write = 1'b0;
    b0.req_address = '0;
    b0.req_data = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(b1.req_ready), 0);
    check("rst_rsp_valid", 32'(b1.rsp_valid), 0);
    check("rst_rsp_data", 32'(b1.rsp_data), 32'hffff);
    check("rst_boot_done", 32'(b1.boot_done), 0);
    reset_n = 1'b1;
    boot_wait();
    model_boot();

    tbl[0]  = '{1'b0, 16'h3000, 16'h0000, 16'h9040};
    tbl[1]  = '{1'b0, 16'h3001, 16'h0000, 16'h5060};
    tbl[2]  = '{1'b0, 16'h3002, 16'h0000, 16'h1027};
    tbl[3]  = '{1'b0, 16'h3003, 16'h0000, 16'h103f};
    tbl[4]  = '{1'b0, 16'h3004, 16'h0000, 16'h0bfe};
    tbl[5]  = '{1'b0, 16'h3005, 16'h0000, 16'hf030};
    tbl[6]  = '{1'b0, 16'h3006, 16'h0000, 16'h0ff9};
    tbl[7]  = '{1'b0, 16'h3007, 16'h0000, 16'hffff};
    tbl[8]  = '{1'b1, 16'h3080, 16'h1234, 16'h1234};
    tbl[9]  = '{1'b0, 16'h3080, 16'h0000, 16'h1234};
    tbl[10] = '{1'b0, 16'h2fff, 16'h0000, 16'hffff};
    tbl[11] = '{1'b0, 16'h3100, 16'h0000, 16'hffff};
    tbl[12] = '{1'b1, 16'h3002, 16'habcd, WP ? 16'h1027 : 16'habcd};
    tbl[13] = '{1'b0, 16'h3002, 16'h0000, WP ? 16'h1027 : 16'habcd};
    tbl[14] = '{1'b1, 16'h2fff, 16'h5555, 16'h5555};

    for (int i = 0; i < 15; i++) begin
      req1(tbl[i].wr, tbl[i].a, tbl[i].d, rsp, lat);
      exp = ref_access(tbl[i].wr, tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d_data", i), 32'(rsp), 32'(tbl[i].e));
      check($sformatf("tbl%0d_lat", i), 32'(lat), 2);
    end
    req1(1'b0, 16'h30ff, 16'h0, rsp, lat);
    check("last_word", 32'(rsp), 32'hffff);

    for (int i = 0; i < 150; i++) begin
      logic        wr;
      logic [15:0] a;
      logic [15:0] d;
      wr = 1'($urandom_range(0, 1));
      a  = 16'h2ff0 + 16'($urandom_range(0, 'h120));
      d  = 16'($urandom);
      exp = ref_access(wr, a, d);
      req1(wr, a, d, rsp, lat);
      check($sformatf("rnd%0d_%h", i, a), 32'(rsp), 32'(exp));
      check("rnd_lat", 32'(lat), 2);
    end

    begin
      logic [15:0] expq [$];
      int last;
      int nreq;
      int nrsp;
      bit gap_bad;
      last = -1;
      nreq = 0;
      nrsp = 0;
      gap_bad = 1'b0;
      b0.req_write = 1'b0;
      b0.req_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
        if (b0.rsp_valid) begin
          if (expq.size() == 0) check("stream_extra", 1, 0);
          else check("stream_data", 32'(b0.rsp_data),
                     32'(expq.pop_front()));
          if (last >= 0 && c - last != 2) gap_bad = 1'b1;
          last = c;
          nrsp++;
        end
        if (b0.req_ready) begin
          b0.req_address = 16'h3000 + 16'(nreq * 15);
          expq.push_back(boot_ref(nreq * 15));
          nreq++;
        end
        @(negedge clk);
      end
      b0.req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (b0.rsp_valid) begin
          if (expq.size() == 0) check("stream_extra", 1, 0);
          else check("stream_data", 32'(b0.rsp_data),
                     32'(expq.pop_front()));
          nrsp++;
        end
        @(negedge clk);
      end
      check("stream_drained", 32'(expq.size()), 0);
      check("stream_gap", 32'(gap_bad), 0);
      check("stream_count", 32'(nrsp), 32'(nreq));
      check("stream_min", 32'(nrsp >= 15), 1);
    end

    begin
      int seen;
      seen = 0;
      check("pre_wr_ready", 32'(b1.req_ready), 1);
      b1.req_valid = 1'b1;
      b1.req_write = 1'b1;
      b1.req_address = 16'h3005;
      b1.req_data = 16'h1111;
      @(posedge clk);
      @(negedge clk);
      b1.req_valid = 1'b0;
      check("in_wait_quiet", 32'(b1.rsp_valid), 0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_data", 32'(b1.rsp_data), 32'hffff);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (b1.rsp_valid) seen++;
      end
      check("dropped_rsp", 32'(seen), 0);
      reset_n = 1'b1;
      boot_wait();
      model_boot();
      req1(1'b0, 16'h3005, 16'h0, rsp, lat);
      check("reboot_3005", 32'(rsp), 32'hf030);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
